// File: rtl/hazard_forward_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_unit_pkg
// Brief    : Shared select encodings and pipeline slot record for the
//            hazard / forwarding unit.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_forward_unit_pkg;

   localparam int REG_ADDR_W = 5;

   localparam logic [1:0] FWD_DATA = 2'b00;
   localparam logic [1:0] FWD_EX   = 2'b01;
   localparam logic [1:0] FWD_MEM  = 2'b10;

   typedef struct packed {
      logic                  valid;
      logic [REG_ADDR_W-1:0] rd;
      logic                  reg_write;
      logic                  mem_read;
   } slot_t;

endpackage
`default_nettype wire

// File: rtl/hazard_forward_unit_fwd_operand_cmp.sv
`default_nettype none
// ============================================================================
// Module   : fwd_operand_cmp
// Brief    : Bypass select for one EX-stage operand; the younger EX slot
//            takes priority over the MEM slot, register 0 is never bypassed.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_operand_cmp
   import hazard_forward_unit_pkg::*;
#(
   parameter int REG_ADDR_W = 5
) (
   input  logic [REG_ADDR_W-1:0] src,
   input  logic                  src_used,
   input  logic                  ex_valid,
   input  logic                  ex_reg_write,
   input  logic [REG_ADDR_W-1:0] ex_rd,
   input  logic                  mem_valid,
   input  logic                  mem_reg_write,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   output logic [1:0]            sel
);

   logic w_ex_hit;
   logic w_mem_hit;

   assign w_ex_hit  = src_used && ex_valid && ex_reg_write
                      && (ex_rd != '0) && (ex_rd == src);
   assign w_mem_hit = src_used && mem_valid && mem_reg_write
                      && (mem_rd != '0) && (mem_rd == src);

   always_comb begin
      sel = FWD_DATA;
      if (w_ex_hit)
         sel = FWD_EX;
      else if (w_mem_hit)
         sel = FWD_MEM;
   end

endmodule
`default_nettype wire

// File: rtl/hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : hazard_forward_unit
// Brief    : Load-use stall detection and registered EX operand bypass select
//            for a 5-stage pipeline, tracking the EX and MEM slots.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_forward_unit
   import hazard_forward_unit_pkg::*;
#(
   parameter int REG_ADDR_W  = 5,
   parameter int STALL_CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   id_valid,
   input  logic [REG_ADDR_W-1:0]  id_rs,
   input  logic [REG_ADDR_W-1:0]  id_rt,
   input  logic                   id_use_rs,
   input  logic                   id_use_rt,
   input  logic [REG_ADDR_W-1:0]  id_rd,
   input  logic                   id_reg_write,
   input  logic                   id_mem_read,
   input  logic                   hold_in,
   output logic [1:0]             fwd_a_sel,
   output logic [1:0]             fwd_b_sel,
   output logic                   stall,
   output logic                   bubble_ex,
   output logic [STALL_CNT_W-1:0] stall_count
);

   localparam slot_t c_slot_empty = '0;

   slot_t                  r_ex;
   slot_t                  r_mem;
   logic [1:0]             r_fwd_a_sel;
   logic [1:0]             r_fwd_b_sel;
   logic                   r_bubble_ex;
   logic [STALL_CNT_W-1:0] r_stall_count;

   logic                   w_stall;
   logic [1:0]             w_sel_a;
   logic [1:0]             w_sel_b;
   slot_t                  w_id_slot;

   // Only a load in EX can't be bypassed in time; everything else forwards.
   assign w_stall = id_valid && r_ex.valid && r_ex.mem_read && r_ex.reg_write
                    && (r_ex.rd != '0)
                    && ((id_use_rs && (id_rs == r_ex.rd))
                        || (id_use_rt && (id_rt == r_ex.rd)));

   assign w_id_slot.valid     = id_valid;
   assign w_id_slot.rd        = id_rd;
   assign w_id_slot.reg_write = id_reg_write;
   assign w_id_slot.mem_read  = id_mem_read;

   fwd_operand_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rs (
      .src           (id_rs),
      .src_used      (id_use_rs),
      .ex_valid      (r_ex.valid),
      .ex_reg_write  (r_ex.reg_write),
      .ex_rd         (r_ex.rd),
      .mem_valid     (r_mem.valid),
      .mem_reg_write (r_mem.reg_write),
      .mem_rd        (r_mem.rd),
      .sel           (w_sel_a)
   );

   fwd_operand_cmp #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_rt (
      .src           (id_rt),
      .src_used      (id_use_rt),
      .ex_valid      (r_ex.valid),
      .ex_reg_write  (r_ex.reg_write),
      .ex_rd         (r_ex.rd),
      .mem_valid     (r_mem.valid),
      .mem_reg_write (r_mem.reg_write),
      .mem_rd        (r_mem.rd),
      .sel           (w_sel_b)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex          <= c_slot_empty;
         r_mem         <= c_slot_empty;
         r_fwd_a_sel   <= FWD_DATA;
         r_fwd_b_sel   <= FWD_DATA;
         r_bubble_ex   <= 1'b1;
         r_stall_count <= '0;
      end else if (!hold_in) begin
         r_mem <= r_ex;
         if (w_stall) begin
            r_ex        <= c_slot_empty;
            r_fwd_a_sel <= FWD_DATA;
            r_fwd_b_sel <= FWD_DATA;
            r_bubble_ex <= 1'b1;
            if (r_stall_count != '1)
               r_stall_count <= r_stall_count + 1'b1;
         end else begin
            r_ex        <= w_id_slot;
            r_fwd_a_sel <= w_sel_a;
            r_fwd_b_sel <= w_sel_b;
            r_bubble_ex <= !id_valid;
         end
      end
   end

   assign fwd_a_sel   = r_fwd_a_sel;
   assign fwd_b_sel   = r_fwd_b_sel;
   assign stall       = w_stall;
   assign bubble_ex   = r_bubble_ex;
   assign stall_count = r_stall_count;

endmodule
`default_nettype wire

// File: tb/tb_hazard_forward_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_forward_unit
// Brief    : Directed self-checking bench for hazard_forward_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_forward_unit;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic        id_use_rs;
   logic        id_use_rt;
   logic [4:0]  id_rd;
   logic        id_reg_write;
   logic        id_mem_read;
   logic        hold_in;
   logic [1:0]  fwd_a_sel;
   logic [1:0]  fwd_b_sel;
   logic        stall;
   logic        bubble_ex;
   logic [15:0] stall_count;

   int n_checks;
   int n_fail;

   hazard_forward_unit #(.REG_ADDR_W(5), .STALL_CNT_W(16)) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .id_valid     (id_valid),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_use_rs    (id_use_rs),
      .id_use_rt    (id_use_rt),
      .id_rd        (id_rd),
      .id_reg_write (id_reg_write),
      .id_mem_read  (id_mem_read),
      .hold_in      (hold_in),
      .fwd_a_sel    (fwd_a_sel),
      .fwd_b_sel    (fwd_b_sel),
      .stall        (stall),
      .bubble_ex    (bubble_ex),
      .stall_count  (stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Drive one decode instruction, then let combinational outputs settle.
   task automatic set_id(input logic v, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt, input logic [4:0] rd,
                         input logic rw, input logic mr);
      id_valid     = v;
      id_rs        = rs;
      id_use_rs    = urs;
      id_rt        = rt;
      id_use_rt    = urt;
      id_rd        = rd;
      id_reg_write = rw;
      id_mem_read  = mr;
      #1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_outs(input string tag, input logic [1:0] a, input logic [1:0] b,
                           input logic bub, input logic [15:0] cnt);
      chk({tag, ".a"}, {30'd0, fwd_a_sel}, {30'd0, a});
      chk({tag, ".b"}, {30'd0, fwd_b_sel}, {30'd0, b});
      chk({tag, ".bub"}, {31'd0, bubble_ex}, {31'd0, bub});
      chk({tag, ".cnt"}, {16'd0, stall_count}, {16'd0, cnt});
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      hold_in  = 1'b0;
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      #12;
      chk_outs("reset", 2'b00, 2'b00, 1'b1, 16'd0);
      chk("reset.stall", {31'd0, stall}, 32'd0);
      rst_n = 1'b1;
      step();

      // add r3 ; add r4,r3,r5
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
      chk("ex_fwd.stall0", {31'd0, stall}, 32'd0);
      step();
      set_id(1'b1, 5'd3, 1'b1, 5'd5, 1'b1, 5'd4, 1'b1, 1'b0);
      chk("ex_fwd.stall1", {31'd0, stall}, 32'd0);
      step();
      chk_outs("ex_fwd", 2'b01, 2'b00, 1'b0, 16'd0);

      // add r3 ; nop ; sub r6,r7,r3
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
      step();
      set_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      step();
      chk("nop.bub", {31'd0, bubble_ex}, 32'd1);
      set_id(1'b1, 5'd7, 1'b1, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0);
      step();
      chk_outs("mem_fwd", 2'b00, 2'b10, 1'b0, 16'd0);

      // lw r2 ; add r8,r2,r2
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5'd2, 1'b1, 5'd2, 1'b1, 5'd8, 1'b1, 1'b0);
      chk("lu.stall1", {31'd0, stall}, 32'd1);
      step();
      chk_outs("lu.bubble", 2'b00, 2'b00, 1'b1, 16'd1);
      chk("lu.stall2", {31'd0, stall}, 32'd0);
      step();
      chk_outs("lu.fwd", 2'b10, 2'b10, 1'b0, 16'd1);

      // add r0 ; add r9,r0,r0 ; lw r0 ; use r0
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9, 1'b1, 1'b0);
      chk("r0.stall", {31'd0, stall}, 32'd0);
      step();
      chk_outs("r0.fwd", 2'b00, 2'b00, 1'b0, 16'd1);
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd10, 1'b1, 1'b0);
      chk("r0lw.stall", {31'd0, stall}, 32'd0);
      step();

      // add r3 ; add r3,r3 ; hold 3 cycles ; use r3,r3
      set_id(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0);
      step();
      set_id(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
      step();
      chk_outs("young.pre", 2'b01, 2'b00, 1'b0, 16'd1);
      set_id(1'b1, 5'd3, 1'b1, 5'd3, 1'b1, 5'd11, 1'b1, 1'b0);
      hold_in = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk_outs("hold", 2'b01, 2'b00, 1'b0, 16'd1);
      end
      hold_in = 1'b0;
      step();
      chk_outs("young", 2'b01, 2'b01, 1'b0, 16'd1);

      // lw r2 ; dependent held two cycles: single count
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd2, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5'd2, 1'b1, 5'd4, 1'b1, 5'd12, 1'b1, 1'b0);
      hold_in = 1'b1;
      for (int i = 0; i < 2; i++) begin
         step();
         chk("hstall.stall", {31'd0, stall}, 32'd1);
         chk("hstall.cnt", {16'd0, stall_count}, 32'd1);
      end
      hold_in = 1'b0;
      step();
      chk_outs("hstall.rel", 2'b00, 2'b00, 1'b1, 16'd2);
      chk("hstall.stall_done", {31'd0, stall}, 32'd0);
      step();

      // lw r5 ; dependent ; reset mid-stall
      set_id(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1);
      step();
      set_id(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 5'd11, 1'b1, 1'b0);
      chk("rst.stall_pre", {31'd0, stall}, 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk_outs("rst.mid", 2'b00, 2'b00, 1'b1, 16'd0);
      chk("rst.stall", {31'd0, stall}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("rst.stall_post", {31'd0, stall}, 32'd0);
      step();
      chk_outs("rst.first", 2'b00, 2'b00, 1'b0, 16'd0);
      set_id(1'b1, 5'd11, 1'b1, 5'd0, 1'b0, 5'd13, 1'b1, 1'b0);
      step();
      chk_outs("rst.resume", 2'b01, 2'b00, 1'b0, 16'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter REG_ADDR_W, default 5: register-number width.
REQ-002 Parameter STALL_CNT_W, default 16: stall statistics counter width.
REQ-003 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 id_valid  input  1  decode stage holds a real instruction.
REQ-006 id_rs, id_rt  input  REG_ADDR_W each  decode source registers.
REQ-007 id_use_rs, id_use_rt  input  1 each  decode instruction reads rs / rt.
REQ-008 id_rd  input  REG_ADDR_W  decode destination register.
REQ-009 id_reg_write  input  1  decode instruction writes id_rd.
REQ-010 id_mem_read  input  1  decode instruction is a load.
REQ-011 hold_in  input  1  external freeze, e.g. memory wait.
REQ-012 fwd_a_sel, fwd_b_sel  output  2 each  registered EX-stage operand select: 00 register-file data, 01 EX/MEM result, 10 MEM/WB result; 11 never driven.
REQ-013 stall  output  1  combinational; hold PC and IF/ID this cycle.
REQ-014 bubble_ex  output  1  registered; current EX-stage instruction is an inserted bubble.
REQ-015 stall_count  output  STALL_CNT_W  saturating count of load-use stall cycles.

Function
REQ-016 The block SHALL track two slots, EX and MEM; each slot holds valid, rd, reg_write and mem_read.
REQ-017 Each rising edge with hold_in=0: MEM slot <= EX slot; EX slot <= decode fields, or a bubble (valid=0) when stall=1.
REQ-018 With hold_in=1, slots, fwd_*_sel, bubble_ex and stall_count SHALL hold their values.
REQ-019 stall SHALL be 1 iff id_valid, EX.valid, EX.mem_read, EX.reg_write, EX.rd!=0, and (id_use_rs and id_rs==EX.rd, or id_use_rt and id_rt==EX.rd).
REQ-020 stall SHALL be evaluated regardless of hold_in; while held, the same stall persists without a double count.
REQ-021 On an advancing edge, per operand: sel<=01 if EX.valid, EX.reg_write, EX.rd!=0, EX.rd==operand, operand used, and stall=0.
REQ-022 Otherwise sel<=10 if the same conditions hold against the MEM slot, mem_read ignored.
REQ-023 Otherwise sel<=00; EX priority over MEM when both match.
REQ-024 On a stall edge, both sels SHALL load 00 and bubble_ex SHALL load 1; otherwise bubble_ex loads !id_valid.
REQ-025 A load followed by a dependent instruction SHALL give exactly one stall cycle, then sel 10 for that operand.
REQ-026 Register 0 SHALL never be forwarded or cause a stall.
REQ-027 Instructions older than the MEM slot SHALL NOT be tracked; the register file writes before it reads.
REQ-028 stall_count SHALL increment by 1 on each advancing edge with stall=1, saturating at all-ones.

Reset
REQ-029 rst_n=0 SHALL immediately clear both slots to invalid, fwd_a_sel=fwd_b_sel=00, bubble_ex=1 and stall_count=0.
REQ-030 With slots invalid after reset, stall SHALL be 0.
REQ-031 Reset mid-stall SHALL abandon the stall; the first post-reset edge treats the decode instruction as new.

Structure
REQ-032 A shared package SHALL hold select encodings FWD_DATA=00, FWD_EX=01, FWD_MEM=10, REG_ADDR_W, and the slot record type.
REQ-033 One sub-module, fwd_operand_cmp, SHALL compute the 2-bit select for one operand from the EX and MEM slots; it is instantiated for rs and rt.

Verification
REQ-034 add r3 then add r4,r3,r5 -> second instruction in EX: fwd_a_sel=01, stall never 1.
REQ-035 add r3, nop, sub r6,r7,r3 -> sub in EX: fwd_b_sel=10, fwd_a_sel=00.
REQ-036 lw r2 then add r8,r2,r2 -> stall=1 exactly one cycle, bubble_ex=1 next, then fwd_a_sel=fwd_b_sel=10; stall_count=1.
REQ-037 add r0,... then add r9,r0,r0 -> sels 00, no stall.
REQ-038 add r3 then add r3 then use r3 -> sel 01 (youngest wins); hold_in=1 for 3 cycles mid-sequence -> all outputs frozen, stall_count unchanged.
REQ-039 rst_n asserted during a load-use stall -> outputs at reset values without a clock edge; stall_count=0; normal forwarding resumes after release.
